inst_mem_pipe: RTL
==================

Name: inst_mem_pipe

Overview:
Parametrised, pipelined, byte-addressed instruction/data-read memory; successor to the 256x8 combinational instruction RAM. Replaces the level-sensitive Enable read with a valid/ready request port, a configurable read latency, and response backpressure. Supports byte, halfword and word reads, flags misaligned or out-of-range accesses, and provides a byte-wide preload port for filling from an image file. Sits between the fetch stage of the pipelined CPU and its program store.

Parameters:
ADDR_W, 32, request address width
DEPTH_BYTES, 256, number of bytes in the array (power of two, >=4)
LATENCY, 1, request-accept to response cycles (1..4)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  read request present
req_ready  out  1  request accepted when req_valid && req_ready at a clk edge
req_addr  in  ADDR_W  byte address
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response when rsp_valid && rsp_ready
rsp_data  out  32  read data, big-endian, zero-extended into the LSBs
rsp_err  out  1  access error, qualified by rsp_valid
load_en  in  1  preload write strobe
load_addr  in  ADDR_W  preload byte address
load_data  in  8  preload byte

Behaviour:
- Reset (async, rst_n=0): all pipeline valid bits clear. rsp_valid=0, rsp_data=0, rsp_err=0. req_ready follows its equation (1 when load_en=0). Array contents are not reset and are retained across reset.
- Array: DEPTH_BYTES x 8.
- Preload:
  - load_en=1 writes load_data to byte load_addr at the clk edge.
  - Writes with load_addr >= DEPTH_BYTES are dropped silently.
  - While load_en=1, req_ready=0. Loads have priority, so a load and a read never collide in the same cycle.
- Pipeline: LATENCY stages, each holding valid, data[31:0] and err. The last stage drives the rsp_* outputs.
  - advance = !stage_last.valid || rsp_ready.
  - When advance=1, every stage shifts by one.
  - When advance=0, all stages hold. The pipeline does not compress bubbles.
  - req_ready = advance && !load_en.
  - An accepted request enters stage 1 at the edge. With no stall, rsp_valid rises LATENCY cycles after the accept edge.
- Data formation (computed at accept):
  - word: {M[a], M[a+1], M[a+2], M[a+3]}
  - half: {16'h0, M[a], M[a+1]}
  - byte: {24'h0, M[a]}
- Error conditions (err=1 and data=0):
  - word with a[1:0]!=0
  - half with a[0]!=0
  - req_size=11
  - a + nbytes > DEPTH_BYTES, where nbytes is 1, 2 or 4. The comparison is done at ADDR_W+1 bits so the address cannot wrap around.
- A response is held stable (data, err and valid) while rsp_valid=1 and rsp_ready=0.
- A stage slot that receives no request (req_valid=0 or load_en=1) gets valid=0.
- Throughput: with rsp_ready held at 1, one response per cycle.
- Reset mid-operation: all in-flight requests are discarded and no response is produced for them.

Decomposition:
- Shared package inst_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - function nbytes(size)
  - constant MAX_LATENCY=4
- One sub-module, inst_mem_stage: a single pipeline register (valid/data/err) with hold enable and async active-low clear. It is instantiated LATENCY times via generate.
- Array, address check and byte assembly stay in the top module.

Test Plan:
1. Preload bytes 0..7 = 00,11,22,33,44,55,66,77. Word read at addr 0 with LATENCY=1 -> one cycle later rsp_valid=1, rsp_data=32'h00112233, rsp_err=0. Word read at addr 4 -> 32'h44556677.
2. Half read at 2 -> 32'h00002233. Byte read at 5 -> 32'h00000055. Half read at 3 -> rsp_err=1, rsp_data=0. Word read at 2 -> rsp_err=1.
3. DEPTH_BYTES=256: word read at 252 -> ok. Word read at 253 -> err. Byte read at 255 -> ok. Byte read at 256 -> err. Word read at 32'hFFFFFFFC -> err (no wrap).
4. LATENCY=3, four back-to-back word requests to 0,4,8,12 with rsp_ready=1 -> responses on cycles 3..6, in order.
5. LATENCY=3, rsp_ready=0 after the first response -> req_ready drops the same cycle and the response holds stable. Release rsp_ready -> the remaining responses arrive in order, none lost or duplicated.
6. Assert load_en while req_valid=1 -> req_ready=0 and no response is generated for that cycle. Pulse rst_n low with two requests in flight -> rsp_valid=0 immediately. After reset, a re-read of addr 0 returns 32'h00112233, confirming array retention.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared size encodings, latency bound and byte-count helper for inst_mem_pipe.
package inst_mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int MAX_LATENCY = 4;

    // Reserved size yields 0 bytes; callers flag it as an error separately.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : size == SZ_WORD ? 3'd4 : 3'd0;
    endfunction
endpackage

// File: rtl/inst_mem_stage.sv
// inst_mem_stage: one response pipeline register (valid/data/err) with hold enable and async clear.
module inst_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_err,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_err
);
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    always_comb begin
        valid_d = en ? in_valid : valid_q;
        data_d  = en ? in_data : data_q;
        err_d   = en ? in_err : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;
endmodule

// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: pipelined byte-addressed read memory with valid/ready ports, backpressure and preload.
module inst_mem_pipe
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH_BYTES);

    logic [7:0]        mem [DEPTH_BYTES];
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W:0]   end_addr;
    logic              advance, acc_valid, acc_err;
    logic [31:0]       acc_data;
    logic              st_valid [LATENCY];
    logic [31:0]       st_data [LATENCY];
    logic              st_err [LATENCY];

    always_ff @(posedge clk) begin
        if (load_en && {1'b0, load_addr} < DEPTH_X)
            mem[load_addr[IDX_W-1:0]] <= load_data;
    end

    // End address is one bit wider than the request so addresses near the top cannot wrap into range.
    always_comb begin
        idx       = req_addr[IDX_W-1:0];
        end_addr  = {1'b0, req_addr} + (ADDR_W + 1)'(nbytes(req_size));
        acc_err   = req_size == 2'b11
                 || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                 || (req_size == SZ_HALF && req_addr[0])
                 || end_addr > DEPTH_X;
        acc_data  = acc_err ? 32'h0
                  : req_size == SZ_WORD ? {mem[idx], mem[idx + IDX_W'(1)], mem[idx + IDX_W'(2)], mem[idx + IDX_W'(3)]}
                  : req_size == SZ_HALF ? {16'h0, mem[idx], mem[idx + IDX_W'(1)]}
                  : {24'h0, mem[idx]};
        advance   = !st_valid[LATENCY-1] || rsp_ready;
        req_ready = advance && !load_en;
        acc_valid = req_valid && req_ready;
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_first
            inst_mem_stage u_stage (
                .clk(clk), .rst_n(rst_n), .en(advance),
                .in_valid(acc_valid), .in_data(acc_data), .in_err(acc_err),
                .out_valid(st_valid[g]), .out_data(st_data[g]), .out_err(st_err[g])
            );
        end else begin : g_rest
            inst_mem_stage u_stage (
                .clk(clk), .rst_n(rst_n), .en(advance),
                .in_valid(st_valid[g-1]), .in_data(st_data[g-1]), .in_err(st_err[g-1]),
                .out_valid(st_valid[g]), .out_data(st_data[g]), .out_err(st_err[g])
            );
        end
    end

    assign rsp_valid = st_valid[LATENCY-1];
    assign rsp_data  = st_data[LATENCY-1];
    assign rsp_err   = st_err[LATENCY-1];
endmodule
